fir_axil_regfile: RTL and testbench
===================================

FIR_AXIL_REGFILE -- requirements
Module: fir_axil_regfile

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, data bus width; legal values 32 or 64.
REQ-002 C_NUM_REGS, 4, register count; power of two, 4..64.
REQ-003 C_S_AXI_ADDR_WIDTH, 4, byte address width; SHALL equal clog2(C_NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8), else elaboration error.
REQ-004 C_ID_VALUE, 32'h0001_0000, read-only ID word (used only under REQ-030).
REQ-005 ACLK  in  1  single clock; all logic rising-edge.
REQ-006 ARESET  in  1  asynchronous, active-high reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored.
REQ-008 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
REQ-009 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel; ARPROT ignored.
REQ-011 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
REQ-012 reg_q  out  C_NUM_REGS*DATA_WIDTH  flattened register contents to FIR core; register k at bits [k*DW +: DW].
REQ-013 reg_wr_pulse  out  C_NUM_REGS  one-cycle strobe per register on committed write.

Function
REQ-014 Register index = ADDR[ADDR_WIDTH-1 : clog2(DW/8)]; low byte-offset bits ignored.
REQ-015 AW and W channels independent; either may arrive first or both in same cycle; each latched into its own holding register.
REQ-016 AWREADY high iff no AW latched and BVALID low; WREADY high iff no W latched and BVALID low.
REQ-017 Commit cycle = first cycle with both AW and W latched; at its closing edge: byte lanes with WSTRB=1 updated, others unchanged; reg_wr_pulse[idx] high for exactly the following cycle; BVALID=1, BRESP=OKAY from following cycle; holding registers cleared.
REQ-018 BVALID held with BRESP stable until BREADY sampled high; deasserts the cycle after handshake; AWREADY/WREADY reassert same cycle BVALID falls.
REQ-019 WSTRB=0 commit: no data change, reg_wr_pulse still asserted, BRESP=OKAY.
REQ-020 Write latency: AW+W handshake in cycle N -> commit cycle N+1 -> BVALID and new reg_q in cycle N+2.
REQ-021 ARREADY high iff RVALID low; AR handshake in cycle N -> RVALID=1 with RDATA, RRESP in cycle N+1.
REQ-022 RDATA sampled from register contents at AR handshake edge; commit on same edge to same register returns old value.
REQ-023 RVALID/RDATA/RRESP held stable until RREADY high; one outstanding read, one outstanding write; read and write paths fully concurrent.
REQ-024 Outputs after reset: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, reg_wr_pulse=0, reg_q=0.

Reset
REQ-025 ARESET assertion SHALL immediately (asynchronously) force all REQ-024 values and clear holding registers.
REQ-026 Reset mid-transaction discards latched AW/W and pending B/R; no commit occurs; no response issued after release.
REQ-027 Reset release synchronous to ACLK; first handshake accepted on first rising edge with ARESET low.

Configuration
REQ-028 Macro FIR_AXIL_RO_ID_EN selects read-only ID register.
REQ-029 Undefined: all C_NUM_REGS registers read/write per REQ-017.
REQ-030 Defined: index C_NUM_REGS-1 is read-only, reads return C_ID_VALUE (zero-extended), RRESP=OKAY; writes to it change nothing, give no reg_wr_pulse, BRESP=SLVERR (2'b10); its reg_q slice = C_ID_VALUE.

Verification
REQ-031 Defaults: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> RDATA 0x1..0x4, all RESP=OKAY, one reg_wr_pulse each.
REQ-032 W precedes AW by 3 cycles, data 0xDEADBEEF addr 0x8 -> BVALID exactly 2 cycles after AW handshake, reg_q[95:64]=0xDEADBEEF.
REQ-033 Reg 1 =0xFFFFFFFF, write 0x12345678 WSTRB=4'b0101 -> readback 0xFF34FF78.
REQ-034 BREADY held low 10 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout, next write accepted after handshake.
REQ-035 AW handshake done, W pending, ARESET pulsed -> no register change, BVALID never asserts, reg_q=0.
REQ-036 FIR_AXIL_RO_ID_EN, write 0xA5A5A5A5 to 0xC -> BRESP=SLVERR, readback 0x00010000, reg_wr_pulse[3] never high.

Source files
------------

// File: rtl/fir_axil_regfile_if.sv
// rtl/fir_axil_regfile_if.sv - AXI4-Lite slave bus bundle for the FIR coefficient register file
//
// Purpose : groups the five AXI4-Lite channels into one port.
// Modports: slave  - register-file side (drives READY/B/R)
//           master - bus-initiator side (drives addresses, data, VALID, BREADY/RREADY)
interface fir_axil_regfile_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]              S_AXI_AWPROT;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]              S_AXI_ARPROT;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]              S_AXI_RRESP;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/fir_axil_regfile.sv
// rtl/fir_axil_regfile.sv - AXI4-Lite register file feeding FIR core configuration
//
// Purpose : C_NUM_REGS x C_S_AXI_DATA_WIDTH read/write registers behind an
//           AXI4-Lite slave with independent AW/W holding registers, byte
//           strobes, one outstanding write and one outstanding read.
// Ports   : ACLK         - clock, rising edge
//           ARESET       - asynchronous active-high reset
//           s_axi        - AXI4-Lite slave bundle (fir_axil_regfile_if.slave)
//           reg_q        - flattened register contents, register k at [k*DW +: DW]
//           reg_wr_pulse - one-cycle strobe per register after a committed write
// Options : FIR_AXIL_RO_ID_EN - top register becomes a read-only ID word
//           (C_ID_VALUE); writes to it answer SLVERR and change nothing.
module fir_axil_regfile #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_NUM_REGS         = 4,
   parameter int          C_S_AXI_ADDR_WIDTH = 4,
   parameter logic [31:0] C_ID_VALUE         = 32'h0001_0000
) (
   input  logic                                    ACLK,
   input  logic                                    ARESET,
   fir_axil_regfile_if.slave                       s_axi,
   output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
   output logic [C_NUM_REGS-1:0]                    reg_wr_pulse
);
   localparam int DW      = C_S_AXI_DATA_WIDTH;
   localparam int AW      = C_S_AXI_ADDR_WIDTH;
   localparam int NB      = DW / 8;
   localparam int IDX_LSB = $clog2(NB);
   localparam int IDX_W   = $clog2(C_NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   if (DW != 32 && DW != 64) begin : g_bad_dw
      $error("C_S_AXI_DATA_WIDTH must be 32 or 64");
   end
   if (C_NUM_REGS < 4 || C_NUM_REGS > 64 || (1 << IDX_W) != C_NUM_REGS) begin : g_bad_nregs
      $error("C_NUM_REGS must be a power of two in 4..64");
   end
   if (AW != IDX_W + IDX_LSB) begin : g_bad_aw
      $error("C_S_AXI_ADDR_WIDTH must equal clog2(C_NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8)");
   end

   // Holding registers for the independent AW and W channels
   logic             aw_held_q;
   logic [IDX_W-1:0] aw_idx_q;
   logic             w_held_q;
   logic [DW-1:0]    w_data_q;
   logic [NB-1:0]    w_strb_q;
   // Response channels
   logic             bvalid_q;
   logic [1:0]       bresp_q;
   logic             rvalid_q;
   logic [DW-1:0]    rdata_q;
   // Register storage
   logic [DW-1:0]          regs_q [C_NUM_REGS];
   logic [C_NUM_REGS-1:0]  wr_pulse_q;

   logic             awready, wready, arready;
   logic             aw_hs, w_hs, ar_hs, commit, ro_hit;
   logic [IDX_W-1:0] aw_idx_d, ar_idx;
   logic [DW-1:0]    wr_word_d, rd_word_d;

   // A pending write response blocks new AW/W so only one write is in flight.
   assign awready = !aw_held_q && !bvalid_q;
   assign wready  = !w_held_q  && !bvalid_q;
   assign arready = !rvalid_q;

   assign aw_hs  = s_axi.S_AXI_AWVALID && awready;
   assign w_hs   = s_axi.S_AXI_WVALID  && wready;
   assign ar_hs  = s_axi.S_AXI_ARVALID && arready;
   assign commit = aw_held_q && w_held_q;

   assign aw_idx_d = s_axi.S_AXI_AWADDR[AW-1:IDX_LSB];
   assign ar_idx   = s_axi.S_AXI_ARADDR[AW-1:IDX_LSB];

   // Byte-lane merge of the held write data into the addressed register
   always_comb begin
      wr_word_d = regs_q[aw_idx_q];
      for (int b = 0; b < NB; b++) begin
         if (w_strb_q[b]) begin
            wr_word_d[b*8 +: 8] = w_data_q[b*8 +: 8];
         end
      end
   end

`ifdef FIR_AXIL_RO_ID_EN
   assign ro_hit    = (aw_idx_q == IDX_W'(C_NUM_REGS-1));
   assign rd_word_d = (ar_idx == IDX_W'(C_NUM_REGS-1)) ? DW'(C_ID_VALUE) : regs_q[ar_idx];
`else
   assign ro_hit    = 1'b0;
   assign rd_word_d = regs_q[ar_idx];
`endif

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         wr_pulse_q <= '0;
         for (int k = 0; k < C_NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         wr_pulse_q <= '0;

         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= aw_idx_d;
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= s_axi.S_AXI_WDATA;
            w_strb_q <= s_axi.S_AXI_WSTRB;
         end

         // Commit cannot coincide with a new AW/W handshake: both holders are full.
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            if (ro_hit) begin
               bresp_q <= RESP_SLVERR;
            end else begin
               regs_q[aw_idx_q]     <= wr_word_d;
               wr_pulse_q[aw_idx_q] <= 1'b1;
               bresp_q              <= RESP_OKAY;
            end
         end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end

         // rd_word_d reads pre-edge contents, so a same-edge commit returns the old value.
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word_d;
         end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   assign s_axi.S_AXI_AWREADY = awready;
   assign s_axi.S_AXI_WREADY  = wready;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = RESP_OKAY;
   assign reg_wr_pulse        = wr_pulse_q;

   for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_flat
`ifdef FIR_AXIL_RO_ID_EN
      if (k == C_NUM_REGS-1) begin : g_id
         assign reg_q[k*DW +: DW] = DW'(C_ID_VALUE);
      end else begin : g_rw
         assign reg_q[k*DW +: DW] = regs_q[k];
      end
`else
      assign reg_q[k*DW +: DW] = regs_q[k];
`endif
   end

   // Protection bits and byte-offset address bits carry no meaning here.
   logic unused_bits;
`ifdef FIR_AXIL_RO_ID_EN
   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[IDX_LSB-1:0], s_axi.S_AXI_ARADDR[IDX_LSB-1:0]};
`else
   assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[IDX_LSB-1:0], s_axi.S_AXI_ARADDR[IDX_LSB-1:0],
                          C_ID_VALUE};
`endif
endmodule

// File: tb/tb_fir_axil_regfile.sv
// tb/tb_fir_axil_regfile.sv - directed self-checking bench for fir_axil_regfile
module tb_fir_axil_regfile;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fir_axil_regfile_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
   logic [127:0] reg_q;
   logic [3:0]   wr_pulse;

   fir_axil_regfile dut (
      .ACLK         (clk),
      .ARESET       (rst),
      .s_axi        (bus),
      .reg_q        (reg_q),
      .reg_wr_pulse (wr_pulse)
   );

`ifdef FIR_AXIL_RO_ID_EN
   localparam bit RO = 1'b1;
`else
   localparam bit RO = 1'b0;
`endif
   localparam logic [31:0]  ID_VAL    = 32'h0001_0000;
   localparam logic [127:0] RESET_REG = RO ? {ID_VAL, 96'h0} : 128'h0;

   int checks = 0;
   int errors = 0;
   int pulse_cnt [4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_pulse[i]) pulse_cnt[i]++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_WVALID  = 1'b1;
      for (int t = 0; t < 20 && (bus.S_AXI_AWVALID || bus.S_AXI_WVALID); t++) begin
         logic aw_go, w_go;
         aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         w_go  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         @(negedge clk);
         if (aw_go) bus.S_AXI_AWVALID = 1'b0;
         if (w_go)  bus.S_AXI_WVALID  = 1'b0;
      end
      checks++;
      if (bus.S_AXI_AWVALID || bus.S_AXI_WVALID) begin
         errors++;
         $display("FAIL write_handshake got aw=%0b w=%0b pending want none", bus.S_AXI_AWVALID, bus.S_AXI_WVALID);
         bus.S_AXI_AWVALID = 1'b0;
         bus.S_AXI_WVALID  = 1'b0;
      end
   endtask

   task automatic wait_bresp(output logic [1:0] resp);
      for (int t = 0; t < 20 && !bus.S_AXI_BVALID; t++) @(negedge clk);
      checks++;
      if (bus.S_AXI_BVALID !== 1'b1) begin
         errors++;
         $display("FAIL bvalid_timeout got %b want 1", bus.S_AXI_BVALID);
      end
      resp = bus.S_AXI_BRESP;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
      send_write(addr, data, strb);
      wait_bresp(resp);
   endtask

   task automatic do_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      for (int t = 0; t < 20 && !bus.S_AXI_ARREADY; t++) @(negedge clk);
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      checks++;
      if (bus.S_AXI_RVALID !== 1'b1) begin
         errors++;
         $display("FAIL read_latency got rvalid=%b want 1", bus.S_AXI_RVALID);
      end
      data = bus.S_AXI_RDATA;
      resp = bus.S_AXI_RRESP;
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL reset_ready got %b want 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
      end
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, wr_pulse} !== 10'b0) begin
         errors++;
         $display("FAIL reset_resp got %b want 0", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, wr_pulse});
      end
      checks++;
      if (bus.S_AXI_RDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h want 0", bus.S_AXI_RDATA);
      end
      checks++;
      if (reg_q !== RESET_REG) begin
         errors++;
         $display("FAIL reset_regq got %h want %h", reg_q, RESET_REG);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_defaults();
      logic [1:0]  resp;
      logic [31:0] data;
      int snap [4];
      for (int i = 0; i < 4; i++) snap[i] = pulse_cnt[i];
      for (int i = 0; i < 4; i++) begin
         logic [3:0] a;
         a = 4'(i * 4);
         do_write(a, 32'(i + 1), 4'hF, resp);
         checks++;
         if (resp !== ((RO && i == 3) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL default_bresp[%0d] got %b want %b", i, resp, (RO && i == 3) ? 2'b10 : 2'b00);
         end
      end
      for (int i = 0; i < 4; i++) begin
         logic [3:0] a;
         a = 4'(i * 4);
         do_read(a, data, resp);
         checks++;
         if (data !== ((RO && i == 3) ? ID_VAL : 32'(i + 1)) || resp !== 2'b00) begin
            errors++;
            $display("FAIL default_read[%0d] got %h/%b want %h/00", i, data, resp, (RO && i == 3) ? ID_VAL : 32'(i + 1));
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pulse_cnt[i] - snap[i] !== ((RO && i == 3) ? 0 : 1)) begin
            errors++;
            $display("FAIL default_pulses[%0d] got %0d want %0d", i, pulse_cnt[i] - snap[i], (RO && i == 3) ? 0 : 1);
         end
      end
   endtask

   task automatic test_w_first();
      bus.S_AXI_WDATA  = 32'hDEAD_BEEF;
      bus.S_AXI_WSTRB  = 4'hF;
      bus.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_WVALID = 1'b0;
      checks++;
      if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY} !== 2'b01) begin
         errors++;
         $display("FAIL wfirst_ready got %b want 01", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY});
      end
      repeat (2) @(negedge clk);
      bus.S_AXI_AWADDR  = 4'h8;
      bus.S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b0) begin
         errors++;
         $display("FAIL wfirst_early_bvalid got %b want 0", bus.S_AXI_BVALID);
      end
      @(negedge clk);
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, wr_pulse} !== 7'b1_00_0100) begin
         errors++;
         $display("FAIL wfirst_bvalid got %b want 1000100", {bus.S_AXI_BVALID, bus.S_AXI_BRESP, wr_pulse});
      end
      checks++;
      if (reg_q[95:64] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL wfirst_regq got %h want deadbeef", reg_q[95:64]);
      end
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic test_strobe();
      logic [1:0]  resp;
      logic [31:0] data;
      int snap;
      do_write(4'h4, 32'hFFFF_FFFF, 4'hF, resp);
      do_write(4'h4, 32'h1234_5678, 4'b0101, resp);
      do_read(4'h4, data, resp);
      checks++;
      if (data !== 32'hFF34_FF78) begin
         errors++;
         $display("FAIL strobe_read got %h want ff34ff78", data);
      end
      snap = pulse_cnt[1];
      do_write(4'h4, 32'h0000_0000, 4'b0000, resp);
      checks++;
      if (resp !== 2'b00 || pulse_cnt[1] - snap !== 1) begin
         errors++;
         $display("FAIL strobe0_resp got %b/%0d want 00/1", resp, pulse_cnt[1] - snap);
      end
      do_read(4'h4, data, resp);
      checks++;
      if (data !== 32'hFF34_FF78) begin
         errors++;
         $display("FAIL strobe0_read got %h want ff34ff78", data);
      end
   endtask

   task automatic test_bready_stall();
      logic [1:0]  resp;
      logic [31:0] data;
      send_write(4'h0, 32'h55AA_55AA, 4'hF);
      for (int t = 0; t < 20 && !bus.S_AXI_BVALID; t++) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 5'b1_00_00) begin
            errors++;
            $display("FAIL stall_cycle%0d got %b want 10000", c, {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
         end
         @(negedge clk);
      end
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      checks++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b011) begin
         errors++;
         $display("FAIL stall_release got %b want 011", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
      end
      do_write(4'h0, 32'h0BAD_F00D, 4'hF, resp);
      do_read(4'h0, data, resp);
      checks++;
      if (data !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL stall_next_write got %h want 0badf00d", data);
      end
   endtask

   task automatic test_same_edge_read();
      logic [1:0]  resp;
      logic [31:0] data;
      bus.S_AXI_AWADDR  = 4'h0;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = 32'h1111_2222;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_WVALID  = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_ARADDR  = 4'h0;
      bus.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      checks++;
      if ({bus.S_AXI_RVALID, bus.S_AXI_BVALID} !== 2'b11 || bus.S_AXI_RDATA !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL same_edge_read got %b/%h want 11/0badf00d", {bus.S_AXI_RVALID, bus.S_AXI_BVALID}, bus.S_AXI_RDATA);
      end
      bus.S_AXI_RREADY = 1'b1;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      do_read(4'h0, data, resp);
      checks++;
      if (data !== 32'h1111_2222) begin
         errors++;
         $display("FAIL same_edge_after got %h want 11112222", data);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0]  resp;
      logic [31:0] data;
      bus.S_AXI_AWADDR  = 4'h4;
      bus.S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      checks++;
      if (bus.S_AXI_AWREADY !== 1'b0) begin
         errors++;
         $display("FAIL midreset_aw_held got %b want 0", bus.S_AXI_AWREADY);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 2'b10 || reg_q !== RESET_REG) begin
         errors++;
         $display("FAIL midreset_async got %b/%h want 10/%h", {bus.S_AXI_AWREADY, bus.S_AXI_BVALID}, reg_q, RESET_REG);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.S_AXI_BVALID, wr_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_quiet%0d got %b want 0", c, {bus.S_AXI_BVALID, wr_pulse});
         end
      end
      checks++;
      if (reg_q !== RESET_REG) begin
         errors++;
         $display("FAIL midreset_regq got %h want %h", reg_q, RESET_REG);
      end
      do_write(4'h8, 32'h0000_0077, 4'hF, resp);
      do_read(4'h8, data, resp);
      checks++;
      if (data !== 32'h0000_0077) begin
         errors++;
         $display("FAIL midreset_after got %h want 00000077", data);
      end
   endtask

`ifdef FIR_AXIL_RO_ID_EN
   task automatic test_ro_id();
      logic [1:0]  resp;
      logic [31:0] data;
      int snap;
      snap = pulse_cnt[3];
      do_write(4'hC, 32'hA5A5_A5A5, 4'hF, resp);
      checks++;
      if (resp !== 2'b10) begin
         errors++;
         $display("FAIL ro_bresp got %b want 10", resp);
      end
      do_read(4'hC, data, resp);
      checks++;
      if (data !== ID_VAL || resp !== 2'b00 || pulse_cnt[3] !== snap || reg_q[127:96] !== ID_VAL) begin
         errors++;
         $display("FAIL ro_read got %h/%b/%0d/%h want %h/00/%0d/%h", data, resp, pulse_cnt[3], reg_q[127:96], ID_VAL, snap, ID_VAL);
      end
   endtask
`endif

   initial begin
      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWPROT  = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b0;
      bus.S_AXI_ARADDR  = '0;
      bus.S_AXI_ARPROT  = '0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b0;
      test_reset();
      test_defaults();
      test_w_first();
      test_strobe();
      test_bready_stall();
      test_same_edge_read();
      test_reset_mid();
`ifdef FIR_AXIL_RO_ID_EN
      test_ro_id();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
